obi_sbr_mem: RTL and testbench

//  OBI subordinate backed by a flop-based word memory. It sits directly downstream
//  of obi_master and terminates its A/R channels. It serves one outstanding

---
 rtl/obi_sbr_mem.sv | 127 ++++++++++++
 tb/tb_obi_sbr_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sbr_mem.sv
// OBI subordinate terminating the A/R channels with a flop-based word memory.
// Define OBI_SBR_ERR_EN to flag invalid decodes on obi_err_o; otherwise err is tied low.
module obi_sbr_mem #(
   parameter int unsigned              ADDR_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH = 32,
   parameter int unsigned              NUM_WORDS  = 16,
   parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
   parameter int unsigned              GNT_WAIT   = 0,
   localparam int unsigned             BE_W       = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  obi_req_i,
   output logic                  obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0] obi_addr_i,
   input  logic                  obi_we_i,
   input  logic [BE_W-1:0]       obi_be_i,
   input  logic [DATA_WIDTH-1:0] obi_wdata_i,
   output logic                  obi_rvalid_o,
   input  logic                  obi_rready_i,
   output logic [DATA_WIDTH-1:0] obi_rdata_o,
   output logic                  obi_err_o
);

   localparam int unsigned           OFF_W     = $clog2(BE_W);
   localparam int unsigned           IDX_W     = $clog2(NUM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] SPAN      = ADDR_WIDTH'(NUM_WORDS * BE_W);
   localparam logic [3:0]            WAIT_LAST = 4'(GNT_WAIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT} state_t;

   state_t                               state_q;
   logic [3:0]                           wait_cnt_q;
   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_q;
   logic                                 rvalid_q;
   logic [DATA_WIDTH-1:0]                rdata_q;

   logic [ADDR_WIDTH-1:0] off;
   logic [IDX_W-1:0]      idx;
   logic                  hit, slot_free, grant_en, accept;

   // Offset wraps modulo 2^ADDR_WIDTH, so addresses below BASE_ADDR land far out of range.
   assign off       = obi_addr_i - BASE_ADDR;
   assign idx       = off[OFF_W +: IDX_W];
   assign hit       = (off < SPAN) && (off[OFF_W-1:0] == '0);
   assign slot_free = !rvalid_q || obi_rready_i;
   assign grant_en  = (state_q == S_ACCEPT) || (GNT_WAIT == 0);
   assign obi_gnt_o = obi_req_i && grant_en && slot_free;
   assign accept    = obi_req_i && obi_gnt_o;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (obi_req_i) begin
               if (GNT_WAIT <= 1) begin
                  state_q <= S_ACCEPT;
               end else begin
                  state_q    <= S_WAIT;
                  wait_cnt_q <= 4'd1;
               end
            end
            S_WAIT: begin
               if (!obi_req_i) begin
                  state_q    <= S_IDLE;
                  wait_cnt_q <= '0;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_q    <= S_ACCEPT;
                  wait_cnt_q <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 4'd1;
               end
            end
            S_ACCEPT: if (!obi_req_i) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         mem_q <= '0;
      end else if (accept && obi_we_i && hit) begin
         for (int b = 0; b < BE_W; b++) begin
            if (obi_be_i[b]) mem_q[idx][b*8 +: 8] <= obi_wdata_i[b*8 +: 8];
         end
      end
   end

   // A new accept overrides the retire of the previous response in the same cycle.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else if (accept) begin
         rvalid_q <= 1'b1;
         rdata_q  <= (!obi_we_i && hit) ? mem_q[idx] : '0;
      end else if (rvalid_q && obi_rready_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end
   end

   assign obi_rvalid_o = rvalid_q;
   assign obi_rdata_o  = rdata_q;

`ifdef OBI_SBR_ERR_EN
   logic err_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= !hit;
      end else if (rvalid_q && obi_rready_i) begin
         err_q <= 1'b0;
      end
   end

   assign obi_err_o = err_q;
`else
   assign obi_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Bench for obi_sbr_mem: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level memory model.
module tb_obi_sbr_mem;

   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic        req = 1'b0, req2 = 1'b0;
   logic        gnt, gnt2;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid, rvalid2;
   logic        rready = 1'b1;
   logic [31:0] rdata, rdata2;
   logic        err, err2;

   int tests = 0;
   int fails = 0;

`ifdef OBI_SBR_ERR_EN
   localparam bit EXP_ERR = 1'b1;
`else
   localparam bit EXP_ERR = 1'b0;
`endif

   always #5 clk = ~clk;

   obi_sbr_mem dut (
      .clk_i(clk), .reset_ni(reset_ni), .obi_req_i(req), .obi_gnt_o(gnt),
      .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
      .obi_rvalid_o(rvalid), .obi_rready_i(rready), .obi_rdata_o(rdata), .obi_err_o(err)
   );

   obi_sbr_mem #(.GNT_WAIT(2)) dut_w2 (
      .clk_i(clk), .reset_ni(reset_ni), .obi_req_i(req2), .obi_gnt_o(gnt2),
      .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
      .obi_rvalid_o(rvalid2), .obi_rready_i(rready), .obi_rdata_o(rdata2), .obi_err_o(err2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One complete transaction on the default instance; rready held high.
   task automatic do_txn(input string name, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_e);
      bit ok = 1'b0;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; be = b; wdata = d; rready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (gnt) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check({name, " gnt"}, 32'(ok), 32'd1);
      @(negedge clk);
      req = 1'b0;
      #1;
      check({name, " rvalid"}, 32'(rvalid), 32'd1);
      check({name, " rdata"}, rdata, exp_rd);
      check({name, " err"}, 32'(err), 32'(exp_e));
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vt[13];

   logic [31:0] mmem[16];
   bit          pend;
   logic [31:0] p_rd;
   bit          p_err;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
      vt[1]  = '{1'b0, 32'h04, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h08, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
      vt[3]  = '{1'b1, 32'h08, 4'h3, 32'h12345678, 32'h0,        1'b0};
      vt[4]  = '{1'b0, 32'h08, 4'hF, 32'h0,        32'hFFFF5678, 1'b0};
      vt[5]  = '{1'b1, 32'h40, 4'hF, 32'h000000A5, 32'h0,        EXP_ERR};
      vt[6]  = '{1'b0, 32'h40, 4'hF, 32'h0,        32'h0,        EXP_ERR};
      vt[7]  = '{1'b0, 32'h02, 4'hF, 32'h0,        32'h0,        EXP_ERR};
      vt[8]  = '{1'b0, 32'h00, 4'hF, 32'h0,        32'h0,        1'b0};
      vt[9]  = '{1'b1, 32'h04, 4'h0, 32'h0,        32'h0,        1'b0};
      vt[10] = '{1'b0, 32'h04, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
      vt[11] = '{1'b1, 32'h3C, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
      vt[12] = '{1'b0, 32'h3C, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      reset_ni = 1'b1;
      @(negedge clk);
      #1;
      check("reset gnt", 32'(gnt), 32'd0);
      check("reset rvalid", 32'(rvalid), 32'd0);
      check("reset rdata", rdata, 32'h0);
      check("reset err", 32'(err), 32'd0);
      check("reset rvalid w2", 32'(rvalid2), 32'd0);

      foreach (vt[i])
         do_txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata,
                vt[i].exp_rdata, vt[i].exp_err);

      // Backpressure: stalled response blocks grant, release grants in same cycle
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h04; rready = 1'b0;
      #1;
      check("T3 first gnt", 32'(gnt), 32'd1);
      @(negedge clk);
      addr = 32'h08;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("T3 stall%0d rvalid", i), 32'(rvalid), 32'd1);
         check($sformatf("T3 stall%0d rdata", i), rdata, 32'hDEADBEEF);
         check($sformatf("T3 stall%0d gnt", i), 32'(gnt), 32'd0);
         @(negedge clk);
      end
      rready = 1'b1;
      #1;
      check("T3 release gnt", 32'(gnt), 32'd1);
      @(negedge clk);
      req = 1'b0;
      #1;
      check("T3 next rvalid", 32'(rvalid), 32'd1);
      check("T3 next rdata", rdata, 32'hFFFF5678);
      @(negedge clk);
      #1;
      check("T3 drained", 32'(rvalid), 32'd0);

      // Grant wait states on the GNT_WAIT=2 instance, then an abandoned request
      addr = 32'h04;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         req2 = 1'b1;
         for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("T4 p%0d c%0d gnt", pass, c), 32'(gnt2), 32'(c == 2));
            @(negedge clk);
         end
         req2 = 1'b0;
         #1;
         check($sformatf("T4 p%0d rvalid", pass), 32'(rvalid2), 32'd1);
         @(negedge clk);
         #1;
         check($sformatf("T4 p%0d retired", pass), 32'(rvalid2), 32'd0);
         if (pass == 0) begin
            @(negedge clk);
            req2 = 1'b1;
            #1;
            check("T4 drop c0 gnt", 32'(gnt2), 32'd0);
            @(negedge clk);
            req2 = 1'b0;
            #1;
            check("T4 drop c1 gnt", 32'(gnt2), 32'd0);
            repeat (3) @(negedge clk);
            #1;
            check("T4 drop no rvalid", 32'(rvalid2), 32'd0);
         end
      end

      // Reset while a write response is pending
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF; wdata = 32'h55; rready = 1'b0;
      #1;
      check("T6 gnt", 32'(gnt), 32'd1);
      @(negedge clk);
      req = 1'b0;
      #1;
      check("T6 rvalid before", 32'(rvalid), 32'd1);
      #2;
      reset_ni = 1'b0;
      #1;
      check("T6 async rvalid", 32'(rvalid), 32'd0);
      @(negedge clk);
      reset_ni = 1'b1;
      rready = 1'b1;
      do_txn("T6 read", 1'b0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0);

      // Randomized traffic against the memory model; model memory matches post-reset DUT
      foreach (mmem[i]) mmem[i] = '0;
      pend = 1'b0;
      p_rd = '0;
      p_err = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         int  a;
         bit  exp_gnt, valid;
         @(negedge clk);
         a = 4 * int'($urandom_range(0, 19));
         if ($urandom_range(0, 7) == 0) a += int'($urandom_range(1, 3));
         req    = ($urandom_range(0, 3) != 0);
         we     = $urandom_range(0, 1) == 1;
         addr   = 32'(a);
         be     = 4'($urandom);
         wdata  = $urandom;
         rready = ($urandom_range(0, 3) != 0);
         #1;
         exp_gnt = req && (!pend || rready);
         check("rnd gnt", 32'(gnt), 32'(exp_gnt));
         check("rnd rvalid", 32'(rvalid), 32'(pend));
         if (pend) begin
            check("rnd rdata", rdata, p_rd);
            check("rnd err", 32'(err), 32'(p_err));
         end
         if (req && exp_gnt) begin
            valid = (a < 64) && (a % 4 == 0);
            p_rd  = (!we && valid) ? mmem[a / 4] : 32'h0;
            p_err = EXP_ERR && !valid;
            if (we && valid)
               for (int b = 0; b < 4; b++)
                  if (be[b]) mmem[a / 4][b*8 +: 8] = wdata[b*8 +: 8];
            pend = 1'b1;
         end else if (pend && rready) begin
            pend = 1'b0;
         end
      end
      @(negedge clk);
      req = 1'b0; rready = 1'b1;
      @(negedge clk);
      #1;
      check("rnd drained", 32'(rvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
